// File: rtl/mem_req_ctrl_if.sv
// Bundle of request, response and memory-pin signals around mem_req_ctrl.
// The slave modport is the controller's view; master is the surrounding requester/memory.
interface mem_req_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_wr_enable;
  logic              mem_rd_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_wr_enable, mem_rd_enable, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_wr_enable, mem_rd_enable, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// In-order request controller for a single-port memory: one access per cycle,
// read data returned through a credit-protected first-word-fall-through FIFO.
module mem_req_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_req_ctrl_if.slave bus,
  output logic          idle
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [RD_LAT-1:0] rd_tag;

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover every read from acceptance until its response is popped,
  // so the FIFO always has room when a tag reaches the end of the pipe.
  assign bus.req_ready = !rst && (cnt < CNT_W'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_write;
  assign push          = rd_tag[RD_LAT-1];
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;
  assign idle          = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_wr_enable <= 1'b0;
      bus.mem_rd_enable <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_data_in   <= '0;
    end else begin
      bus.mem_wr_enable <= accept && bus.req_write;
      bus.mem_rd_enable <= rd_accept;
      if (accept) begin
        bus.mem_addr    <= bus.req_addr;
        bus.mem_data_in <= bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({rd_accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // One tag per issued read; it lines up with mem_data_out RD_LAT cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag <= '0;
    end else begin
      rd_tag[0] <= bus.mem_rd_enable;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_tag[i] <= rd_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: rsp_rdata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mem_req_ctrl;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 1;
  localparam int RSP_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;

  mem_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .idle(idle)
  );

  always #5 clk = ~clk;

  // 16x8 single-port memory, written at the issue edge, RD_LAT=1 registered read.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (bus.mem_wr_enable) ram[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_rd_enable) bus.mem_data_out <= ram[bus.mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic w, input logic [3:0] a,
                                input logic [7:0] d, input logic rr);
    @(posedge clk);
    #1;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
  endtask

  // Model: contents of memory, a queue of promised responses with the cycle
  // each becomes visible, and the number of reads still owed to the consumer.
  typedef struct {
    logic [7:0] data;
    int         vis;
  } rsp_t;

  rsp_t       q[$];
  logic [7:0] model_mem [16] = '{default: 8'h00};
  int         outstanding = 0;
  logic       pend_wr = 1'b0;
  logic       pend_rd = 1'b0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_data = '0;
  int         cyc = 0;

  always @(negedge clk) begin : model
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_rdata;
    logic       acc;
    if (rst) begin
      check_output("rst_req_ready", {31'b0, bus.req_ready}, 0);
      check_output("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
      check_output("rst_rsp_rdata", {24'b0, bus.rsp_rdata}, 0);
      check_output("rst_wr_en", {31'b0, bus.mem_wr_enable}, 0);
      check_output("rst_rd_en", {31'b0, bus.mem_rd_enable}, 0);
      check_output("rst_addr", {28'b0, bus.mem_addr}, 0);
      check_output("rst_wdata", {24'b0, bus.mem_data_in}, 0);
      check_output("rst_idle", {31'b0, idle}, 1);
      q.delete();
      outstanding = 0;
      pend_wr = 1'b0;
      pend_rd = 1'b0;
      last_addr = '0;
      last_data = '0;
    end else begin
      exp_ready = (outstanding < RSP_DEPTH);
      exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
      exp_rdata = exp_valid ? q[0].data : 8'h00;
      check_output("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
      check_output("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_valid});
      check_output("rsp_rdata", {24'b0, bus.rsp_rdata}, {24'b0, exp_rdata});
      check_output("mem_wr_enable", {31'b0, bus.mem_wr_enable}, {31'b0, pend_wr});
      check_output("mem_rd_enable", {31'b0, bus.mem_rd_enable}, {31'b0, pend_rd});
      check_output("mem_addr", {28'b0, bus.mem_addr}, {28'b0, last_addr});
      check_output("mem_data_in", {24'b0, bus.mem_data_in}, {24'b0, last_data});
      check_output("idle", {31'b0, idle}, {31'b0, outstanding == 0});
      if (exp_valid && bus.rsp_ready) begin
        void'(q.pop_front());
        outstanding--;
      end
      acc = bus.req_valid && exp_ready;
      pend_wr = acc && bus.req_write;
      pend_rd = acc && !bus.req_write;
      if (acc) begin
        last_addr = bus.req_addr;
        last_data = bus.req_wdata;
        if (bus.req_write) begin
          model_mem[bus.req_addr] = bus.req_wdata;
        end else begin
          q.push_back('{data: model_mem[bus.req_addr], vis: cyc + 2 + RD_LAT});
          outstanding++;
        end
      end
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_acc;
    int n_rsp;
    int first_cyc;
    int last_cyc;
    logic [7:0] exp_d;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, then ready on the first edge after release.
    repeat (3) @(negedge clk);
    check_output("reset_ready", {31'b0, bus.req_ready}, 0);
    check_output("reset_idle", {31'b0, idle}, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_reset", {31'b0, bus.req_ready}, 1);

    // Write 0xA5 to addr 3, then read it back the very next cycle.
    apply_stimulus(1, 1, 4'd3, 8'hA5, 1);
    apply_stimulus(1, 0, 4'd3, 8'h00, 1);
    @(negedge clk);
    check_output("wr_strobe", {31'b0, bus.mem_wr_enable}, 1);
    check_output("wr_addr", {28'b0, bus.mem_addr}, 3);
    check_output("wr_data", {24'b0, bus.mem_data_in}, 8'hA5);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("rd_strobe", {31'b0, bus.mem_rd_enable}, 1);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("rsp_not_yet", {31'b0, bus.rsp_valid}, 0);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("raw_rsp_valid", {31'b0, bus.rsp_valid}, 1);
    check_output("raw_rsp_data", {24'b0, bus.rsp_rdata}, 8'hA5);

    // Preload every address with 0x10+addr.
    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 4'(i), 8'(8'h10 + i), 1);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);

    // Backpressure: six reads offered with the consumer stalled.
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1, 0, 4'(i), 8'h00, 0);
      @(negedge clk);
      if (bus.req_ready) n_acc++;
    end
    check_output("bp_accepted", n_acc, 4);
    check_output("bp_ready_low", {31'b0, bus.req_ready}, 0);
    apply_stimulus(0, 0, 4'd0, 8'h00, 0);
    apply_stimulus(0, 0, 4'd0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 4'd0, 8'h00, 1);
      @(negedge clk);
      check_output("bp_rsp_valid", {31'b0, bus.rsp_valid}, 1);
      check_output("bp_rsp_data", {24'b0, bus.rsp_rdata}, 32'(8'h10 + i));
    end
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("bp_drained", {31'b0, bus.rsp_valid}, 0);

    // Credit boundary: fill to four, pop once, refill.
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 4'(i), 8'h00, 0);
    repeat (4) apply_stimulus(0, 0, 4'd0, 8'h00, 0);
    @(negedge clk);
    check_output("credit_full", {31'b0, bus.req_ready}, 0);
    apply_stimulus(1, 0, 4'd5, 8'h00, 1);
    @(negedge clk);
    check_output("credit_pop_cycle", {31'b0, bus.req_ready}, 0);
    apply_stimulus(1, 0, 4'd6, 8'h00, 0);
    @(negedge clk);
    check_output("credit_next_cycle", {31'b0, bus.req_ready}, 1);

    // A write waits for a credit too and must not touch memory meanwhile.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 4'd9, 8'hEE, 0);
      @(negedge clk);
      check_output("wfull_ready", {31'b0, bus.req_ready}, 0);
      check_output("wfull_mem", {24'b0, ram[9]}, 8'h19);
    end
    apply_stimulus(1, 1, 4'd9, 8'hEE, 1);
    @(negedge clk);
    check_output("wfull_pop_cycle", {31'b0, bus.req_ready}, 0);
    apply_stimulus(1, 1, 4'd9, 8'hEE, 0);
    @(negedge clk);
    check_output("wfull_accept", {31'b0, bus.req_ready}, 1);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("wfull_mem_written", {24'b0, ram[9]}, 8'hEE);
    repeat (8) apply_stimulus(0, 0, 4'd0, 8'h00, 1);
    @(negedge clk);
    check_output("idle_after_drain", {31'b0, idle}, 1);

    // Streaming: sixteen back-to-back reads at full rate.
    n_rsp = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int k = 0; k < 24; k++) begin
      apply_stimulus(k < 16, 0, 4'(k), 8'h00, 1);
      @(negedge clk);
      if (k < 16) check_output("stream_ready", {31'b0, bus.req_ready}, 1);
      if (bus.rsp_valid) begin
        exp_d = (n_rsp == 9) ? 8'hEE : 8'(8'h10 + n_rsp);
        check_output("stream_data", {24'b0, bus.rsp_rdata}, {24'b0, exp_d});
        if (first_cyc < 0) first_cyc = k;
        last_cyc = k;
        n_rsp++;
      end
    end
    check_output("stream_count", n_rsp, 16);
    check_output("stream_span", last_cyc - first_cyc, 15);
    check_output("stream_first", first_cyc, 3);

    // Asynchronous reset with two reads in flight.
    apply_stimulus(1, 0, 4'd1, 8'h00, 0);
    apply_stimulus(1, 0, 4'd2, 8'h00, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check_output("arst_rd_en", {31'b0, bus.mem_rd_enable}, 0);
    check_output("arst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    check_output("arst_ready", {31'b0, bus.req_ready}, 0);
    check_output("arst_idle", {31'b0, idle}, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_output("arst_ready_after", {31'b0, bus.req_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 4'd0, 8'h00, 1);
      @(negedge clk);
      check_output("arst_no_stale", {31'b0, bus.rsp_valid}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
